uart_mmio_ctrl: RTL
===================

Name: uart_mmio_ctrl

Overview:
- Memory-mapped I/O controller between the CPU memory stage and the UART serializer/deserializer.
- Decodes CPU loads and stores to the 0x8000_00xx window and buffers TX and RX bytes in FIFOs.
- Drives the UART ready/valid handshakes and stalls the CPU only when a TX store hits a full FIFO.

Parameters:
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr  in  32  CPU memory-stage address
wdata  in  32  CPU store data; bits [7:0] used
we  in  1  CPU store strobe
re  in  1  CPU load strobe
rdata  out  32  load data, registered
stall  out  1  CPU hold request, combinational
DataIn  out  8  byte to UART transmitter
DataInValid  out  1  TX byte valid
DataInReady  in  1  transmitter can accept
DataOut  in  8  byte from UART receiver
DataOutValid  in  1  RX byte valid
DataOutReady  out  1  controller can accept RX byte

Behaviour:
- Reset is asynchronous on reset_n low. While low and on release:
  - both FIFOs empty
  - rdata=0, DataInValid=0, DataIn=0
  - DataOutReady=0 during reset; it rises the first cycle after release
  - overflow flag=0, TX FSM in IDLE
- Register map (exact word address match, all other addresses ignored):
  - 0x80000000 read: bit0=TX FIFO not full, bit1=TX FIFO empty and FSM IDLE.
  - 0x80000004 read: bit0=RX FIFO not empty, bit1=sticky overflow; this read clears overflow.
  - 0x80000008 write: push wdata[7:0] into TX FIFO.
  - 0x8000000C read: pop RX head into rdata[7:0], upper bits 0. When empty, returns 0 and no pop.
- Load latency: rdata is valid the cycle after re; it holds its value until the next decoded load. Unmapped loads leave rdata unchanged.
- stall = we & (addr==0x80000008) & tx_full, using the registered full flag.
  - While stalled, the CPU holds addr/wdata/we.
  - The push occurs in the first cycle stall is low.
  - A TX drain pop in the same cycle frees space for the following cycle, not the current one.
- TX FSM:
  - IDLE: if TX FIFO is not empty, pop the head into DataIn, set DataInValid=1, go to SEND.
  - SEND: hold DataIn and DataInValid until DataInReady=1 is sampled. On that edge, if the FIFO is not empty, pop the next byte and stay in SEND (back-to-back, no bubble); otherwise clear DataInValid and go to IDLE.
- RX path:
  - DataOutReady = ~rx_full (registered flag).
  - A push occurs on DataOutValid & DataOutReady.
  - If DataOutValid=1 while full, set the overflow flag; the byte is dropped and the UART is never blocked.
- Simultaneous RX push and CPU pop on a non-full FIFO: both occur and the count is unchanged. On an empty FIFO the pop returns 0 and the pushed byte is stored.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and low bits equal; empty = pointers equal.
- we and re are never both asserted; if they are, we has priority and rdata holds.
- Reset asserted mid-transfer: the DataInValid and FIFO contents in flight are discarded immediately.

Optional Feature:
- Macro: UART_MMIO_CYCLE_CNT_EN.
- Defined: adds a 32-bit free-running cycle counter.
  - 0x80000010 read returns the counter value; the counter resets to 0 on reset_n.
  - A write of any data to 0x80000018 zeroes the counter in the next cycle.
  - The counter wraps from 0xFFFFFFFF to 0.
- Undefined: no counter logic; 0x80000010 and 0x80000018 are unmapped.

Decomposition:
- Shared package uart_mmio_pkg holds:
  - address constants UART_CTRL_ADDR, UART_RXSTAT_ADDR, UART_TX_ADDR, UART_RX_ADDR, CYCLE_CNT_ADDR, CYCLE_RST_ADDR
  - TX FSM state encoding (IDLE=0, SEND=1)
- One sub-module, sync_fifo, parameterised by WIDTH/DEPTH with outputs full, empty and dout. It is instantiated twice: TX with depth TX_DEPTH, RX with depth RX_DEPTH.

Test Plan:
- Reset: reset_n low mid-SEND with 3 bytes queued -> DataInValid=0 immediately, rdata=0; read of 0x80000000 after release returns 0x3.
- TX burst: store 0x41, 0x42, 0x43 to 0x80000008, DataInReady held 1 -> DataIn shows 0x41, 0x42, 0x43 on consecutive cycles, then DataInValid=0.
- TX full stall: DataInReady=0, 6 stores with TX_DEPTH=4 -> the first byte moves to the SEND register, 4 fill the FIFO, the 6th store sees stall=1. Raising DataInReady for one cycle lets stall drop the next cycle and the 6th byte is accepted.
- RX overflow: 9 bytes 0x01..0x09 offered with no CPU reads, RX_DEPTH=8 -> DataOutReady=0 after the 8th. A read of 0x80000004 returns 0x3, a re-read returns 0x1, and 8 pops of 0x8000000C return 0x01..0x08.
- RX empty and simultaneous: pop on empty -> rdata=0. Push 0x55 in the same cycle as a pop on a 1-entry FIFO holding 0x11 -> rdata=0x11, FIFO count=1, next pop returns 0x55.
- UART_MMIO_CYCLE_CNT_EN: write 0x80000018, wait 10 cycles, read 0x80000010 -> 0x0000000A ±1 for read latency. Without the macro, a write to 0x80000018 has no effect and a read of 0x80000010 leaves rdata unchanged.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// ==========================================================================
// uart_mmio_pkg : shared address map and TX FSM encoding | Rev 1.0
// ==========================================================================
`default_nettype none

package uart_mmio_pkg;

    localparam logic [31:0] UART_CTRL_ADDR   = 32'h8000_0000;
    localparam logic [31:0] UART_RXSTAT_ADDR = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;
    localparam logic [31:0] UART_RX_ADDR     = 32'h8000_000C;
    localparam logic [31:0] CYCLE_CNT_ADDR   = 32'h8000_0010;
    localparam logic [31:0] CYCLE_RST_ADDR   = 32'h8000_0018;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ==========================================================================
// sync_fifo : single-clock FIFO, extra-MSB pointers, head visible on dout | Rev 1.0
// ==========================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset: contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
// ==========================================================================
// uart_mmio_ctrl : CPU MMIO bridge to UART with TX/RX FIFOs; optional
// cycle counter via UART_MMIO_CYCLE_CNT_EN | Rev 1.0
// ==========================================================================
`default_nettype none

module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_dout;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_done;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_dout;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_ready_en;
    logic        overflow;
    logic        hit_tx;
    logic        rd_en;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    // A store wins over a simultaneous load.
    assign rd_en   = re & ~we;
    assign hit_tx  = we & (addr == UART_TX_ADDR);
    assign stall   = hit_tx & tx_full;
    assign tx_push = hit_tx & ~tx_full;
    assign rx_pop  = rd_en & (addr == UART_RX_ADDR) & ~rx_empty;

    assign DataOutReady = rx_ready_en & ~rx_full;
    assign rx_push      = DataOutValid & DataOutReady;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .din     (wdata[7:0]),
        .pop     (tx_pop),
        .dout    (tx_dout),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .din     (DataOut),
        .pop     (rx_pop),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= TX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        tx_done   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (DataInReady) begin
                    if (!tx_empty) begin
                        tx_pop = 1'b1;
                    end else begin
                        tx_done   = 1'b1;
                        state_nxt = TX_IDLE;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DataIn      <= 8'h00;
            DataInValid <= 1'b0;
        end else if (tx_pop) begin
            DataIn      <= tx_dout;
            DataInValid <= 1'b1;
        end else if (tx_done) begin
            DataInValid <= 1'b0;
        end
    end

    // A fresh overflow outranks the clearing status read so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ready_en <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rx_ready_en <= 1'b1;
            if (DataOutValid && rx_full)
                overflow <= 1'b1;
            else if (rd_en && (addr == UART_RXSTAT_ADDR))
                overflow <= 1'b0;
        end
    end

`ifdef UART_MMIO_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle_cnt <= 32'd0;
        else if (we && (addr == CYCLE_RST_ADDR))
            cycle_cnt <= 32'd0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= 32'd0;
        end else if (rd_en) begin
            case (addr)
                UART_CTRL_ADDR:   rdata <= {30'd0, tx_empty & (state == TX_IDLE), ~tx_full};
                UART_RXSTAT_ADDR: rdata <= {30'd0, overflow, ~rx_empty};
                UART_RX_ADDR:     rdata <= rx_empty ? 32'd0 : {24'd0, rx_dout};
`ifdef UART_MMIO_CYCLE_CNT_EN
                CYCLE_CNT_ADDR:   rdata <= cycle_cnt;
`endif
                default:          rdata <= rdata;
            endcase
        end
    end

endmodule

`default_nettype wire
